// File: rtl/jtframe_inputs_n_if.sv
// Bundle of player-input signals between the I/O controller side and the
// input conditioner. The conditioner takes the slave view.
interface jtframe_inputs_n_if #(
  parameter int PLAYERS = 4
);
  logic                    vs;
  logic [16*PLAYERS-1:0]   board_joy;
  logic [1:0]              rotate;
  logic                    autofire_en;
  logic [10*PLAYERS-1:0]   game_joy;
  logic [PLAYERS-1:0]      game_coin;
  logic [PLAYERS-1:0]      game_start;
  logic                    game_service;
  logic                    dip_pause;

  modport master (
    output vs, board_joy, rotate, autofire_en,
    input  game_joy, game_coin, game_start, game_service, dip_pause
  );

  modport slave (
    input  vs, board_joy, rotate, autofire_en,
    output game_joy, game_coin, game_start, game_service, dip_pause
  );
endinterface

// File: rtl/jtframe_inputs_n.sv
// Player-input conditioner: rotation, opposite-direction cleaning, autofire,
// coin stretching, pause toggle and output polarity for PLAYERS channels.
module jtframe_inputs_n #(
  parameter int PLAYERS         = 4,
  parameter int BUTTONS         = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int COIN_FRAMES     = 3,
  parameter int AUTOFIRE_FRAMES = 2
) (
  input  logic              clk_sys,
  input  logic              rst,
  jtframe_inputs_n_if.slave io
);
  localparam logic       POL       = (ACTIVE_LOW != 0);
  localparam logic [5:0] BTN_MASK  = 6'((7'd1 << BUTTONS) - 7'd1);
  localparam logic [3:0] AF_LAST   = 4'(AUTOFIRE_FRAMES - 1);
  localparam logic [7:0] COIN_LOAD = 8'(COIN_FRAMES);

  logic [16*PLAYERS-1:0] joy_reg;
  logic [1:0]            rotate_reg;
  logic                  autofire_reg;
  logic                  vs_reg, vs_last_reg;
  logic                  tick;

  logic [10*PLAYERS-1:0] joy_next;
  logic [PLAYERS-1:0]    coin_next, start_next, pause_bits, service_bits;
  logic                  pause_any;

  logic [10*PLAYERS-1:0] game_joy_reg;
  logic [PLAYERS-1:0]    game_coin_reg, game_start_reg;
  logic                  game_service_reg, pause_reg, pause_last_reg;

  // Stage 1: register raw inputs so every direct path has the same latency
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      joy_reg      <= '0;
      rotate_reg   <= '0;
      autofire_reg <= 1'b0;
      vs_reg       <= 1'b0;
      vs_last_reg  <= 1'b0;
    end else begin
      joy_reg      <= io.board_joy;
      rotate_reg   <= io.rotate;
      autofire_reg <= io.autofire_en;
      vs_reg       <= io.vs;
      vs_last_reg  <= vs_reg;
    end
  end

  assign tick = vs_reg & ~vs_last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PLAYERS; gi++) begin : g_player
      logic [15:0] raw;
      logic [3:0]  dir_rot, dir_clean;
      logic [5:0]  btns;
      logic        btn1, coin, btn1_out;
      logic        btn1_last_reg, phase_reg, phase_next;
      logic [3:0]  af_cnt_reg, af_cnt_next;
      logic        coin_last_reg;
      logic [7:0]  coin_cnt_reg, coin_cnt_next;
      logic        unused_bits;

      assign raw         = joy_reg[16*gi +: 16];
      assign btn1        = raw[4];
      assign coin        = raw[11];
      assign unused_bits = &{1'b0, raw[15:14]};

      // Directions kept as {U,D,L,R}; CW takes U<-L, D<-R, L<-D, R<-U
      always_comb begin
        dir_rot = raw[3:0];
        if (rotate_reg[0])
          dir_rot = rotate_reg[1] ? {raw[0], raw[1], raw[3], raw[2]}
                                  : {raw[1], raw[0], raw[2], raw[3]};
      end

      assign dir_clean = {dir_rot[3] & ~dir_rot[2], dir_rot[2] & ~dir_rot[3],
                          dir_rot[1] & ~dir_rot[0], dir_rot[0] & ~dir_rot[1]};

      always_comb begin
        phase_next  = phase_reg;
        af_cnt_next = af_cnt_reg;
        if (!btn1) begin
          phase_next  = 1'b0;
          af_cnt_next = 4'd0;
        end else if (!btn1_last_reg) begin
          phase_next  = 1'b1;
          af_cnt_next = 4'd0;
        end else if (tick) begin
          if (af_cnt_reg == AF_LAST) begin
            af_cnt_next = 4'd0;
            phase_next  = ~phase_reg;
          end else begin
            af_cnt_next = af_cnt_reg + 4'd1;
          end
        end
      end

      assign btn1_out = btn1 & (phase_next | ~autofire_reg);
      assign btns     = {raw[9:5], btn1_out} & BTN_MASK;

      // A fresh edge only loads an idle counter; the load beats a same-cycle tick
      always_comb begin
        coin_cnt_next = coin_cnt_reg;
        if (coin && !coin_last_reg && (coin_cnt_reg == 8'd0))
          coin_cnt_next = COIN_LOAD;
        else if (tick && (coin_cnt_reg != 8'd0))
          coin_cnt_next = coin_cnt_reg - 8'd1;
      end

      always_ff @(posedge clk_sys) begin
        if (rst) begin
          btn1_last_reg <= 1'b0;
          phase_reg     <= 1'b0;
          af_cnt_reg    <= 4'd0;
          coin_last_reg <= 1'b0;
          coin_cnt_reg  <= 8'd0;
        end else begin
          btn1_last_reg <= btn1;
          phase_reg     <= phase_next;
          af_cnt_reg    <= af_cnt_next;
          coin_last_reg <= coin;
          coin_cnt_reg  <= coin_cnt_next;
        end
      end

      assign joy_next[10*gi +: 10] = {btns, dir_clean};
      assign coin_next[gi]    = (COIN_FRAMES == 0) ? coin : (coin_cnt_next != 8'd0);
      assign start_next[gi]   = raw[10];
      assign pause_bits[gi]   = raw[12];
      assign service_bits[gi] = raw[13];
    end
  endgenerate

  assign pause_any = |pause_bits;

  // Stage 2: output registers, polarity applied last
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      game_joy_reg     <= {(10*PLAYERS){POL}};
      game_coin_reg    <= {PLAYERS{POL}};
      game_start_reg   <= {PLAYERS{POL}};
      game_service_reg <= POL;
      pause_reg        <= 1'b0;
      pause_last_reg   <= 1'b0;
    end else begin
      game_joy_reg     <= joy_next ^ {(10*PLAYERS){POL}};
      game_coin_reg    <= coin_next ^ {PLAYERS{POL}};
      game_start_reg   <= start_next ^ {PLAYERS{POL}};
      game_service_reg <= (|service_bits) ^ POL;
      pause_last_reg   <= pause_any;
      pause_reg        <= pause_reg ^ (pause_any & ~pause_last_reg);
    end
  end

  assign io.game_joy     = game_joy_reg;
  assign io.game_coin    = game_coin_reg;
  assign io.game_start   = game_start_reg;
  assign io.game_service = game_service_reg;
  assign io.dip_pause    = pause_reg;
endmodule

// File: tb/tb_jtframe_inputs_n.sv
// Self-checking bench: two conditioners (active-low and active-high outputs)
// share one stimulus and are compared against a frame-level reference model.
module tb_jtframe_inputs_n;
  localparam int P    = 2;
  localparam int BTNS = 2;
  localparam int AF   = 2;
  localparam int COIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              vs = 1'b0;
  logic [16*P-1:0]   board_joy = '0;
  logic [1:0]        rotate = 2'b00;
  logic              autofire_en = 1'b0;

  int checks = 0;
  int errors = 0;

  jtframe_inputs_n_if #(.PLAYERS(P)) bus_l ();
  jtframe_inputs_n_if #(.PLAYERS(P)) bus_h ();

  assign bus_l.vs = vs;
  assign bus_l.board_joy = board_joy;
  assign bus_l.rotate = rotate;
  assign bus_l.autofire_en = autofire_en;
  assign bus_h.vs = vs;
  assign bus_h.board_joy = board_joy;
  assign bus_h.rotate = rotate;
  assign bus_h.autofire_en = autofire_en;

  jtframe_inputs_n #(.PLAYERS(P), .BUTTONS(BTNS), .ACTIVE_LOW(1),
                     .COIN_FRAMES(COIN), .AUTOFIRE_FRAMES(AF))
    dut_l (.clk_sys(clk), .rst(rst), .io(bus_l.slave));

  jtframe_inputs_n #(.PLAYERS(P), .BUTTONS(BTNS), .ACTIVE_LOW(0),
                     .COIN_FRAMES(COIN), .AUTOFIRE_FRAMES(AF))
    dut_h (.clk_sys(clk), .rst(rst), .io(bus_h.slave));

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One video frame with a random vs shape; long enough for outputs to settle
  task automatic do_frame();
    vs = 1'b1;
    cyc($urandom_range(1, 3));
    vs = 1'b0;
    cyc($urandom_range(3, 6));
  endtask

  // Active-high expected joystick word for a player with btn1 phase at 1
  function automatic logic [9:0] model_player(input logic [15:0] raw, input logic [1:0] rot);
    logic [3:0] ring, turned;   // ring index: 0=U 1=R 2=D 3=L (clockwise order)
    logic [5:0] btn;
    logic       up, dn, lf, rt;
    ring = {raw[1], raw[2], raw[0], raw[3]};
    for (int k = 0; k < 4; k++) begin
      if (!rot[0])     turned[k] = ring[k];
      else if (!rot[1]) turned[k] = ring[(k + 3) % 4];
      else              turned[k] = ring[(k + 1) % 4];
    end
    up = turned[0]; rt = turned[1]; dn = turned[2]; lf = turned[3];
    if (up && dn) begin up = 1'b0; dn = 1'b0; end
    if (lf && rt) begin lf = 1'b0; rt = 1'b0; end
    btn = raw[9:4];
    for (int b = 0; b < 6; b++) if (b >= BTNS) btn[b] = 1'b0;
    return {btn, up, dn, lf, rt};
  endfunction

  task automatic test_reset();
    logic [24:0] act_h, act_l;
    rst = 1'b1;
    board_joy = 32'($urandom);
    vs = 1'b1;
    cyc(3);
    act_h = {bus_h.game_joy, bus_h.game_coin, bus_h.game_start, bus_h.game_service};
    act_l = {bus_l.game_joy, bus_l.game_coin, bus_l.game_start, bus_l.game_service};
    checks++;
    if (act_h !== 25'd0) begin errors++; $display("FAIL reset_high: got %h expected %h", act_h, 25'd0); end
    checks++;
    if (act_l !== {25{1'b1}}) begin errors++; $display("FAIL reset_low: got %h expected %h", act_l, {25{1'b1}}); end
    checks++;
    if ({bus_h.dip_pause, bus_l.dip_pause} !== 2'b00) begin
      errors++; $display("FAIL reset_pause: got %b expected 00", {bus_h.dip_pause, bus_l.dip_pause});
    end
    board_joy = '0;
    vs = 1'b0;
    rst = 1'b0;
    cyc(3);
    $display("reset: outputs inactive during reset checked");
  endtask

  task automatic test_directed();
    logic [19:0] exp_l;
    board_joy = 32'd1 << (16 + 3);
    rotate = 2'b00;
    cyc(1);
    checks++;
    if (bus_l.game_joy !== {20{1'b1}}) begin
      errors++; $display("FAIL p2_up_latency: got %h expected %h", bus_l.game_joy, {20{1'b1}});
    end
    cyc(1);
    exp_l = ~(20'd1 << 13);
    checks++;
    if (bus_l.game_joy !== exp_l) begin errors++; $display("FAIL p2_up: got %h expected %h", bus_l.game_joy, exp_l); end
    rotate = 2'b01;
    board_joy = 32'd1 << 3;
    cyc(2);
    checks++;
    if (bus_h.game_joy !== 20'd1) begin errors++; $display("FAIL rot_cw_up: got %h expected %h", bus_h.game_joy, 20'd1); end
    rotate = 2'b00;
    board_joy = 32'h3;
    cyc(2);
    checks++;
    if (bus_l.game_joy[1:0] !== 2'b11 || bus_h.game_joy !== 20'd0) begin
      errors++; $display("FAIL clean_lr: got %h expected %h", bus_h.game_joy, 20'd0);
    end
    $display("directed: P2 up, CW rotation, L+R cleaning checked");
  endtask

  task automatic test_random_vectors();
    logic [15:0] raw [P];
    logic [24:0] exp_vec, prev_vec, act_h, act_l;
    prev_vec = '0;  // last directed vector (L+R only) yields all-inactive outputs
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < P; p++) raw[p] = 16'($urandom) & 16'hE7FF;
      board_joy = {raw[1], raw[0]};
      rotate = 2'($urandom_range(0, 3));
      autofire_en = 1'($urandom_range(0, 1));
      exp_vec = {model_player(raw[1], rotate), model_player(raw[0], rotate), 2'b00,
                 raw[1][10], raw[0][10], raw[1][13] | raw[0][13]};
      cyc(1);
      act_h = {bus_h.game_joy, bus_h.game_coin, bus_h.game_start, bus_h.game_service};
      checks++;
      if (act_h !== prev_vec) begin errors++; $display("FAIL rand_latency[%0d]: got %h expected %h", i, act_h, prev_vec); end
      cyc(1);
      act_h = {bus_h.game_joy, bus_h.game_coin, bus_h.game_start, bus_h.game_service};
      act_l = {bus_l.game_joy, bus_l.game_coin, bus_l.game_start, bus_l.game_service};
      checks++;
      if (act_h !== exp_vec) begin errors++; $display("FAIL rand_high[%0d]: got %h expected %h", i, act_h, exp_vec); end
      checks++;
      if (act_l !== ~exp_vec) begin errors++; $display("FAIL rand_low[%0d]: got %h expected %h", i, act_l, ~exp_vec); end
      $display("random[%0d]: raw=%h rot=%b exp=%h", i, board_joy, rotate, exp_vec);
      prev_vec = exp_vec;
    end
  endtask

  task automatic test_autofire(input logic en);
    int  ticks;
    logic exp_b;
    autofire_en = en;
    rotate = 2'b00;
    board_joy = '0;
    cyc(3);
    board_joy = (32'd1 << 4) | (32'd1 << 20);
    ticks = 0;
    cyc(2);
    for (int f = 0; f <= 10; f++) begin
      if (f > 0) begin do_frame(); ticks++; end
      exp_b = en ? (((ticks / AF) % 2) == 0) : 1'b1;
      checks++;
      if ({bus_h.game_joy[14], bus_h.game_joy[4]} !== {exp_b, exp_b} ||
          {bus_l.game_joy[14], bus_l.game_joy[4]} !== {~exp_b, ~exp_b}) begin
        errors++;
        $display("FAIL autofire_en%0d_frame%0d: got %b%b expected %b", en, f,
                 bus_h.game_joy[14], bus_h.game_joy[4], exp_b);
      end
      $display("autofire en=%0d frame=%0d btn1 expected %b", en, f, exp_b);
    end
    board_joy = '0;
    cyc(2);
    checks++;
    if ({bus_h.game_joy[14], bus_h.game_joy[4]} !== 2'b00) begin
      errors++; $display("FAIL autofire_release_en%0d: got %b%b expected 00", en, bus_h.game_joy[14], bus_h.game_joy[4]);
    end
  endtask

  task automatic test_coin();
    int pl, remaining;
    logic [P-1:0] exp_c;
    autofire_en = 1'b0;
    board_joy = '0;
    cyc(3);
    pl = $urandom_range(0, P - 1);
    remaining = 0;
    board_joy[16*pl + 11] = 1'b1;
    cyc(1);
    board_joy[16*pl + 11] = 1'b0;
    if (remaining == 0) remaining = COIN;
    cyc(2);
    for (int f = 0; f <= 5; f++) begin
      if (f > 0) begin
        do_frame();
        if (remaining > 0) remaining--;
      end
      if (f == 1) begin
        board_joy[16*pl + 11] = 1'b1;
        cyc(1);
        board_joy[16*pl + 11] = 1'b0;
        if (remaining == 0) remaining = COIN;
        cyc(2);
      end
      exp_c = '0;
      exp_c[pl] = (remaining != 0);
      checks++;
      if (bus_h.game_coin !== exp_c || bus_l.game_coin !== ~exp_c) begin
        errors++; $display("FAIL coin_p%0d_frame%0d: got %b expected %b", pl, f, bus_h.game_coin, exp_c);
      end
      $display("coin p%0d frame=%0d expected %b", pl, f, exp_c);
    end
    // coin edge landing on the same cycle as a frame tick
    vs = 1'b1;
    board_joy[16*pl + 11] = 1'b1;
    cyc(1);
    board_joy[16*pl + 11] = 1'b0;
    cyc(1);
    vs = 1'b0;
    cyc(4);
    remaining = COIN;
    for (int f = 0; f <= 3; f++) begin
      if (f > 0) begin do_frame(); if (remaining > 0) remaining--; end
      exp_c = '0;
      exp_c[pl] = (remaining != 0);
      checks++;
      if (bus_h.game_coin !== exp_c) begin
        errors++; $display("FAIL coin_coincide_frame%0d: got %b expected %b", f, bus_h.game_coin, exp_c);
      end
      $display("coin coincident frame=%0d expected %b", f, exp_c);
    end
  endtask

  task automatic test_pause();
    logic exp_p;
    exp_p = 1'b0;
    board_joy = '0;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      board_joy[16 + 12] = 1'b1;
      cyc($urandom_range(1, 3));
      board_joy[16 + 12] = 1'b0;
      exp_p = ~exp_p;
      cyc(3);
      checks++;
      if (bus_h.dip_pause !== exp_p || bus_l.dip_pause !== exp_p) begin
        errors++; $display("FAIL pause_toggle%0d: got %b/%b expected %b", k, bus_h.dip_pause, bus_l.dip_pause, exp_p);
      end
      $display("pause pulse %0d: dip_pause expected %b", k, exp_p);
    end
    rst = 1'b1;
    cyc(1);
    checks++;
    if (bus_h.dip_pause !== 1'b0 || bus_l.dip_pause !== 1'b0) begin
      errors++; $display("FAIL pause_reset: got %b/%b expected 0", bus_h.dip_pause, bus_l.dip_pause);
    end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_coin_through_reset();
    int remaining;
    autofire_en = 1'b1;
    board_joy = '0;
    cyc(3);
    board_joy[11] = 1'b1;
    board_joy[4] = 1'b1;
    cyc(3);
    checks++;
    if (bus_h.game_coin[0] !== 1'b1) begin errors++; $display("FAIL coin_pre_reset: got %b expected 1", bus_h.game_coin[0]); end
    rst = 1'b1;
    cyc(1);
    checks++;
    if (bus_h.game_coin !== 2'b00 || bus_l.game_coin !== 2'b11) begin
      errors++; $display("FAIL coin_abort: got %b expected 00", bus_h.game_coin);
    end
    cyc(2);
    rst = 1'b0;
    remaining = COIN;
    cyc(2);
    checks++;
    if (bus_h.game_joy[4] !== 1'b1) begin errors++; $display("FAIL btn_after_reset: got %b expected 1", bus_h.game_joy[4]); end
    for (int f = 0; f <= 4; f++) begin
      if (f > 0) begin do_frame(); if (remaining > 0) remaining--; end
      checks++;
      if (bus_h.game_coin[0] !== (remaining != 0) || bus_l.game_coin[0] !== (remaining == 0)) begin
        errors++; $display("FAIL coin_after_reset_frame%0d: got %b expected %b", f, bus_h.game_coin[0], remaining != 0);
      end
      $display("coin held through reset frame=%0d expected %b", f, remaining != 0);
    end
    board_joy = '0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_vectors();
    test_autofire(1'b1);
    test_autofire(1'b0);
    test_coin();
    test_pause();
    test_coin_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
